// File: rtl/matrix_scan_pkg.sv
// Shared definitions for the physics and scan stages: panel geometry and scan FSM states.
package matrix_scan_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        LATCH,
        DISPLAY
    } scan_state_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matrix_scan_counter.sv
// Free-running dwell/phase counter with synchronous clear; saturates instead of wrapping.
module matrix_scan_counter
    import matrix_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    // Count up each cycle, hold at all-ones, restart from zero on clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// Row-scanning driver for a 16x16 shift-register LED panel: snapshot frame,
// shift each row out column 15 first, latch it, then display it for ON_CYCLES.
module matrix_scan
    import matrix_scan_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int ON_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] matrix,
    output logic                 sdata,
    output logic                 sclk,
    output logic                 latch,
    output logic                 oe_n,
    output logic [3:0]           row_addr,
    output logic                 frame_done
);

    if (CLK_DIV < 1 || ON_CYCLES < 1) begin : g_bad_params
        $error("matrix_scan: CLK_DIV and ON_CYCLES must both be at least 1");
    end

    localparam int CNT_W = $clog2(max_i(ON_CYCLES, 2 * CLK_DIV) + 1);

    localparam logic [CNT_W-1:0] SCLK_RISE = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DISP_END  = CNT_W'(ON_CYCLES - 1);

    scan_state_t          state;
    logic [3:0]           row_cnt;
    logic [3:0]           bit_cnt;
    logic [ROWS*COLS-1:0] frame_buf;
    logic [COLS-1:0]      shift_reg;
    logic [COLS-1:0]      row_bits;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_clr;

    matrix_scan_counter #(
        .WIDTH(CNT_W)
    ) u_counter (
        .clk  (clk),
        .clear(cnt_clr),
        .count(cnt)
    );

    // Row 0 reads the live input because the snapshot lands on the same edge.
    always_comb begin
        row_bits = frame_buf[{row_cnt, 4'b0000} +: COLS];
        if (row_cnt == 4'd0) begin
            row_bits = matrix[COLS-1:0];
        end
    end

    // Clear the counter on reset, on every state change and at each bit boundary.
    always_comb begin
        cnt_clr = 1'b0;
        case (state)
            LOAD, LATCH: cnt_clr = 1'b1;
            SHIFT:       cnt_clr = (cnt == BIT_END);
            DISPLAY:     cnt_clr = (cnt == DISP_END);
            default:     cnt_clr = 1'b1;
        endcase
        if (reset) begin
            cnt_clr = 1'b1;
        end
    end

    // Scan FSM with registered panel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            row_cnt    <= '0;
            bit_cnt    <= '0;
            frame_buf  <= '0;
            shift_reg  <= '0;
            sdata      <= 1'b0;
            sclk       <= 1'b0;
            latch      <= 1'b0;
            oe_n       <= 1'b1;
            row_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (row_cnt == 4'd0) begin
                        frame_buf <= matrix;
                    end
                    sdata      <= row_bits[COLS-1];
                    shift_reg  <= {row_bits[COLS-2:0], 1'b0};
                    bit_cnt    <= '0;
                    frame_done <= 1'b0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == SCLK_RISE) begin
                        sclk <= 1'b1;
                    end
                    if (cnt == BIT_END) begin
                        sclk <= 1'b0;
                        if (bit_cnt == 4'(COLS - 1)) begin
                            sdata    <= 1'b0;
                            latch    <= 1'b1;
                            row_addr <= row_cnt;
                            state    <= LATCH;
                        end else begin
                            sdata     <= shift_reg[COLS-1];
                            shift_reg <= {shift_reg[COLS-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                end
                LATCH: begin
                    latch <= 1'b0;
                    oe_n  <= 1'b0;
                    state <= DISPLAY;
                end
                DISPLAY: begin
                    if (cnt == DISP_END) begin
                        oe_n    <= 1'b1;
                        row_cnt <= row_cnt + 4'd1;
                        if (row_cnt == 4'(ROWS - 1)) begin
                            frame_done <= 1'b1;
                        end
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter CLK_DIV, default 2, number of clk cycles in each sclk low phase and each sclk high phase.
REQ-002 Parameter ON_CYCLES, default 1000, number of clk cycles a latched row is displayed.
REQ-003 Port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port matrix  input  256  frame from the physics stage; bit y*16+x is pixel (row y, column x).
REQ-006 Port sdata  output  1  serial column data to the panel shift register.
REQ-007 Port sclk  output  1  panel shift clock; data is sampled by the panel on its rising edge.
REQ-008 Port latch  output  1  one-cycle pulse that transfers the shifted row into the panel output latch.
REQ-009 Port oe_n  output  1  active-low panel output enable.
REQ-010 Port row_addr  output  4  row currently driven.
REQ-011 Port frame_done  output  1  one-cycle pulse after row 15 completes its display phase.

Function
REQ-012 The FSM SHALL have four states: LOAD, SHIFT, LATCH and DISPLAY; the first state after reset is LOAD with the row counter at 0.
REQ-013 In LOAD, when the row counter is 0, the block SHALL snapshot matrix into an internal 256-bit frame buffer; changes to matrix during the rest of the frame SHALL be ignored.
REQ-014 In LOAD, the block SHALL copy frame buffer bits [row*16+15 : row*16] into a 16-bit row shift register, stay 1 cycle, and go to SHIFT.
REQ-015 In SHIFT, the block SHALL output 16 bits, column 15 first and column 0 last.
REQ-016 For each bit in SHIFT, sdata SHALL be stable for 2*CLK_DIV cycles: sclk is 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles.
REQ-017 After the high phase of bit 16, the FSM SHALL go to LATCH with sclk 0.
REQ-018 LATCH SHALL last exactly 1 cycle: latch=1 and row_addr is loaded with the row counter on that same edge; then the FSM goes to DISPLAY.
REQ-019 In DISPLAY, oe_n SHALL be 0 for exactly ON_CYCLES cycles.
REQ-020 In SHIFT, LOAD and LATCH, oe_n SHALL be 1 (the panel is blanked while it is being written).
REQ-021 At the end of DISPLAY, the row counter SHALL increment modulo 16 and the FSM SHALL return to LOAD.
REQ-022 On the 15->0 wrap, frame_done SHALL be 1 for exactly the first LOAD cycle of the new frame.
REQ-023 Row period SHALL be 2 + 32*CLK_DIV + ON_CYCLES cycles: 1066 at the defaults; frame period SHALL be 16x the row period: 17056 at the defaults.
REQ-024 The dwell and phase counters SHALL be sized $clog2(max(ON_CYCLES, 2*CLK_DIV)+1) bits and SHALL NOT wrap within a state.
REQ-025 Elaboration SHALL fail if CLK_DIV<1 or ON_CYCLES<1.
REQ-026 sdata SHALL be 0 outside SHIFT.

Reset
REQ-027 While reset=1 at a clock edge, the next state SHALL be: sdata=0, sclk=0, latch=0, oe_n=1, row_addr=0, frame_done=0, FSM=LOAD, row counter=0, frame buffer=0.
REQ-028 Reset asserted mid-SHIFT or mid-DISPLAY SHALL abort the row immediately with no latch pulse, and the first LOAD after reset SHALL take a fresh snapshot.

Structure
REQ-029 The state enum and the constants ROWS=16 and COLS=16 SHALL live in a shared package used by the physics and scan stages.
REQ-030 The dwell and phase timing SHALL use one instance of the existing Counter sub-module, cleared on reset and on every state transition; there are no other sub-modules.

Verification
REQ-031 Reset held for 3 cycles, then released -> oe_n=1, latch=0, and row_addr=0 throughout reset; the first sclk rising edge occurs CLK_DIV+1 cycles after release.
REQ-032 matrix with only bit 0x00F0 set (row 0, columns 4-7), defaults -> row 0 shifts sdata pattern 0000_0000_1111_0000 (column 15 first) on 16 sclk rising edges; all other rows shift all zeros.
REQ-033 Defaults -> latch pulses are exactly 1066 cycles apart, each pulse lasts 1 cycle, and oe_n is low for exactly 1000 cycles after each latch.
REQ-034 matrix changed at row 5 of a frame -> rows 5-15 still show the old frame, and the new value first appears at row 0 of the next frame.
REQ-035 Count frame_done pulses -> pulses are exactly 17056 cycles apart, and row_addr goes 15 then 0 around each pulse.
REQ-036 Reset asserted in the middle of SHIFT of row 7 -> no latch pulse occurs, and scanning restarts at row 0 with a new snapshot.
